// File: rtl/axi_mem_drain_gate_pkg.sv
// rtl/axi_mem_drain_gate_pkg.sv - shared types for the memory drain gate
//
// Contents: gate FSM state encoding and outstanding-counter width.
package axi_mem_drain_gate_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } gate_state_e;

endpackage

// File: rtl/axi_mem_outstanding_ctr.sv
// rtl/axi_mem_outstanding_ctr.sv - bounded outstanding-burst counter
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc         address handshake this cycle
//   dec         burst-completing response handshake this cycle
//   count       current outstanding bursts (0..LIMIT)
//   ok          room for another burst (count < LIMIT)
//   underflow   pulse: response seen while nothing is outstanding
module axi_mem_outstanding_ctr
  import axi_mem_drain_gate_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ok,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  assign ok        = (count < LIMIT_C);
  assign underflow = dec && (count == '0);

  // Simultaneous inc and dec cancel; both ends saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && (count != LIMIT_C)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_mem_drain_gate.sv
// rtl/axi_mem_drain_gate.sv - AXI4 memory pass-through with burst cap and quiesce handshake
//
// Ports:
//   uncoreclk, uncore_rstn          clock, async active-low reset
//   s_axi_*                         AXI4 slave from the memory master (AW/W/B/AR/R)
//   m_axi_*                         AXI4 master toward the address mapper
//   quiesce_req / quiesce_ack       drain request (level) / quiesced, nothing outstanding
//   rd_outstanding, wr_outstanding  current burst counts
//   proto_err                       sticky: rlast or B seen with nothing outstanding
//   stat_rd_bursts, stat_wr_bursts, stat_stall_cyc
//                                   only when AXI_MEM_DRAIN_GATE_STATS_EN is defined
module axi_mem_drain_gate
  import axi_mem_drain_gate_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int MAX_RD_OUT = 8,
  parameter int MAX_WR_OUT = 8
) (
  input  logic                    uncoreclk,
  input  logic                    uncore_rstn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    quiesce_req,
  output logic                    quiesce_ack,
  output logic [CNT_W-1:0]        rd_outstanding,
  output logic [CNT_W-1:0]        wr_outstanding,
  output logic                    proto_err
`ifdef AXI_MEM_DRAIN_GATE_STATS_EN
  ,
  output logic [31:0]             stat_rd_bursts,
  output logic [31:0]             stat_wr_bursts,
  output logic [31:0]             stat_stall_cyc
`endif
);

  gate_state_e state_q, state_d;
  logic        rd_ok, wr_ok, rd_unf, wr_unf;
  logic        ar_hold, aw_hold, ar_open, aw_open;
  logic        ar_hs, aw_hs, rlast_hs, b_hs, drained;

  // Address payloads pass straight through; only valid/ready are gated.
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;

  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wvalid  = s_axi_wvalid;
  assign s_axi_wready  = m_axi_wready;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;

  // A held request keeps the gate open so a presented valid is never withdrawn.
  assign ar_open       = ((state_q == RUN) && rd_ok) || ar_hold;
  assign aw_open       = ((state_q == RUN) && wr_ok) || aw_hold;
  assign m_axi_arvalid = s_axi_arvalid && ar_open;
  assign s_axi_arready = m_axi_arready && ar_open;
  assign m_axi_awvalid = s_axi_awvalid && aw_open;
  assign s_axi_awready = m_axi_awready && aw_open;

  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign rlast_hs = m_axi_rvalid && s_axi_rready && m_axi_rlast;
  assign b_hs     = m_axi_bvalid && s_axi_bready;

  axi_mem_outstanding_ctr #(.LIMIT(MAX_RD_OUT)) u_rd_ctr (
    .clk(uncoreclk), .rst_n(uncore_rstn), .inc(ar_hs), .dec(rlast_hs),
    .count(rd_outstanding), .ok(rd_ok), .underflow(rd_unf)
  );

  axi_mem_outstanding_ctr #(.LIMIT(MAX_WR_OUT)) u_wr_ctr (
    .clk(uncoreclk), .rst_n(uncore_rstn), .inc(aw_hs), .dec(b_hs),
    .count(wr_outstanding), .ok(wr_ok), .underflow(wr_unf)
  );

  assign drained = (rd_outstanding == '0) && (wr_outstanding == '0) && !ar_hold && !aw_hold;

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      state_q   <= RUN;
      ar_hold   <= 1'b0;
      aw_hold   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      // Presented and not accepted -> hold; accepted -> release.
      if (m_axi_arvalid) ar_hold <= !m_axi_arready;
      if (m_axi_awvalid) aw_hold <= !m_axi_awready;
      if (rd_unf || wr_unf) proto_err <= 1'b1;
    end
  end

  // A drop of quiesce_req during DRAIN wins over a same-cycle empty condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (quiesce_req) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce_req)  state_d = RUN;
        else if (drained)  state_d = IDLE;
      end
      IDLE:    if (!quiesce_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign quiesce_ack = (state_q == IDLE);

`ifdef AXI_MEM_DRAIN_GATE_STATS_EN
  logic stall;
  assign stall = (s_axi_arvalid && !ar_open) || (s_axi_awvalid && !aw_open);

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      stat_rd_bursts <= '0;
      stat_wr_bursts <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (ar_hs) stat_rd_bursts <= stat_rd_bursts + 32'd1;
      if (aw_hs) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (stall && (stat_stall_cyc != '1)) stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_mem_drain_gate.sv
// tb/tb_axi_mem_drain_gate.sv - directed self-checking bench for axi_mem_drain_gate
module tb_axi_mem_drain_gate;

  logic        uncoreclk = 1'b0;
  logic        uncore_rstn;
  logic [0:0]  s_axi_awid, s_axi_arid, m_axi_awid, m_axi_arid;
  logic [39:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
  logic        s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache, m_axi_awcache, m_axi_arcache;
  logic [2:0]  s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
  logic [3:0]  s_axi_awqos, s_axi_arqos, m_axi_awqos, m_axi_arqos;
  logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic [7:0]  s_axi_wstrb, m_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [0:0]  s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
  logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        quiesce_req, quiesce_ack, proto_err;
  logic [3:0]  rd_outstanding, wr_outstanding;
`ifdef AXI_MEM_DRAIN_GATE_STATS_EN
  logic [31:0] stat_rd_bursts, stat_wr_bursts, stat_stall_cyc;
`endif

  int total;
  int bad;

  always #5 uncoreclk = ~uncoreclk;

  axi_mem_drain_gate dut (
    .uncoreclk(uncoreclk), .uncore_rstn(uncore_rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .proto_err(proto_err)
`ifdef AXI_MEM_DRAIN_GATE_STATS_EN
    , .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts),
    .stat_stall_cyc(stat_stall_cyc)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic idle_inputs();
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst} = '0;
    {s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid} = '0;
    {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst} = '0;
    {s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid} = '0;
    {m_axi_bid, m_axi_bresp, m_axi_bvalid} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = '0;
    s_axi_bready  = 1'b1;
    s_axi_rready  = 1'b1;
    m_axi_awready = 1'b1;
    m_axi_arready = 1'b1;
    m_axi_wready  = 1'b1;
    quiesce_req   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    uncore_rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge uncoreclk);
    #1;
    chk4("rst_rd_cnt", rd_outstanding, 4'd0);
    chk4("rst_wr_cnt", wr_outstanding, 4'd0);
    chk1("rst_ack", quiesce_ack, 1'b0);
    chk1("rst_proto_err", proto_err, 1'b0);
    uncore_rstn = 1'b1;
    cyc();

    // Payload pass-through in both directions, no handshakes.
    s_axi_awid = 1'b1; s_axi_awaddr = 40'h12_3456_789A; s_axi_awlen = 8'h0F; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'd1; s_axi_awlock = 1'b1; s_axi_awcache = 4'hA; s_axi_awprot = 3'd5; s_axi_awqos = 4'h6;
    s_axi_arid = 1'b0; s_axi_araddr = 40'hAB_CDEF_0123; s_axi_arlen = 8'h03; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd2; s_axi_arlock = 1'b0; s_axi_arcache = 4'h3; s_axi_arprot = 3'd1; s_axi_arqos = 4'h9;
    s_axi_wdata = 64'hDEAD_BEEF_0BAD_F00D; s_axi_wstrb = 8'hA5; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    m_axi_wready = 1'b0;
    m_axi_bid = 1'b1; m_axi_bresp = 2'd2; m_axi_bvalid = 1'b1; s_axi_bready = 1'b0;
    m_axi_rid = 1'b1; m_axi_rdata = 64'h0123_4567_89AB_CDEF; m_axi_rresp = 2'd3; m_axi_rvalid = 1'b1;
    s_axi_rready = 1'b0;
    #1;
    chkw("pt_aw", 128'({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                        m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}),
                  128'({1'b1, 40'h12_3456_789A, 8'h0F, 3'd3, 2'd1, 1'b1, 4'hA, 3'd5, 4'h6}));
    chkw("pt_ar", 128'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                        m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}),
                  128'({1'b0, 40'hAB_CDEF_0123, 8'h03, 3'd2, 2'd2, 1'b0, 4'h3, 3'd1, 4'h9}));
    chkw("pt_w", 128'({m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid}),
                 128'({64'hDEAD_BEEF_0BAD_F00D, 8'hA5, 1'b1, 1'b1}));
    chkw("pt_b", 128'({s_axi_bid, s_axi_bresp, s_axi_bvalid}), 128'({1'b1, 2'd2, 1'b1}));
    chkw("pt_r", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid}),
                 128'({1'b1, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 1'b1}));
    chkw("pt_rdy_lo", 128'({s_axi_wready, m_axi_bready, m_axi_rready}), 128'(3'b000));
    idle_inputs();
    #1;
    chkw("pt_rdy_hi", 128'({s_axi_wready, m_axi_bready, m_axi_rready}), 128'(3'b111));

    // Test 1: 8 back-to-back ARs fill the cap, 9th waits for an rlast.
    s_axi_arlen = 8'd3;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk1("t1_arready_open", s_axi_arready, 1'b1);
      cyc();
    end
    chk4("t1_rd_full", rd_outstanding, 4'd8);
    #1;
    chk1("t1_9th_arready", s_axi_arready, 1'b0);
    chk1("t1_9th_m_arvalid", m_axi_arvalid, 1'b0);
    cyc();
    chk4("t1_rd_stays_8", rd_outstanding, 4'd8);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    #1 chk1("t1_arready_during_rlast", s_axi_arready, 1'b0);
    cyc();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk4("t1_rd_after_rlast", rd_outstanding, 4'd7);
    #1 chk1("t1_9th_accept", s_axi_arready, 1'b1);
    cyc();
    s_axi_arvalid = 1'b0;
    chk4("t1_rd_refill", rd_outstanding, 4'd8);

    // Test 2: drop to 5, then AR + rlast in the same cycle.
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    repeat (3) cyc();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk4("t2_rd_5", rd_outstanding, 4'd5);
    s_axi_arvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    cyc();
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk4("t2_rd_same_cycle", rd_outstanding, 4'd5);
    // Non-last beat leaves the count alone; then drain to 2 reads and add 1 write.
    m_axi_rvalid = 1'b1;
    cyc();
    chk4("t2_rd_nonlast", rd_outstanding, 4'd5);
    m_axi_rlast = 1'b1;
    repeat (3) cyc();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    s_axi_awvalid = 1'b1;
    cyc();
    s_axi_awvalid = 1'b0;
    chk4("t2_rd_2", rd_outstanding, 4'd2);
    chk4("t2_wr_1", wr_outstanding, 4'd1);

    // Test 3: quiesce with 2 reads + 1 write outstanding.
    quiesce_req = 1'b1;
    cyc();
    s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
    #1;
    chk1("t3_ar_blocked", m_axi_arvalid, 1'b0);
    chk1("t3_aw_blocked", m_axi_awvalid, 1'b0);
    chk1("t3_ar_ready_blocked", s_axi_arready, 1'b0);
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    m_axi_bvalid = 1'b1;
    cyc();
    m_axi_bvalid = 1'b0;
    chk4("t3_wr_0", wr_outstanding, 4'd0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    cyc();
    chk1("t3_ack_pending", quiesce_ack, 1'b0);
    cyc();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk4("t3_rd_0", rd_outstanding, 4'd0);
    chk1("t3_ack_not_yet", quiesce_ack, 1'b0);
    cyc();
    chk1("t3_ack_rise", quiesce_ack, 1'b1);
    quiesce_req = 1'b0;
    #1 chk1("t3_ack_held", quiesce_ack, 1'b1);
    cyc();
    chk1("t3_ack_drop", quiesce_ack, 1'b0);

    // Test 4: AR held by a stalled slave across a quiesce request.
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) quiesce_req = 1'b1;
      #1 chk1("t4_arvalid_stable", m_axi_arvalid, 1'b1);
      cyc();
    end
    chk1("t4_ack_while_held", quiesce_ack, 1'b0);
    m_axi_arready = 1'b1;
    #1 chk1("t4_arready_pass", s_axi_arready, 1'b1);
    cyc();
    s_axi_arvalid = 1'b0;
    chk4("t4_rd_1", rd_outstanding, 4'd1);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    cyc();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk1("t4_ack_not_yet", quiesce_ack, 1'b0);
    cyc();
    chk1("t4_ack_rise", quiesce_ack, 1'b1);
    s_axi_arvalid = 1'b1;
    #1 chk1("t4_idle_ar_blocked", m_axi_arvalid, 1'b0);
    s_axi_arvalid = 1'b0;
    quiesce_req = 1'b0;
    cyc();
    chk1("t4_ack_drop", quiesce_ack, 1'b0);

    // Test 5: B with nothing outstanding, then reset mid-burst.
    m_axi_bvalid = 1'b1;
    cyc();
    m_axi_bvalid = 1'b0;
    chk4("t5_wr_stays_0", wr_outstanding, 4'd0);
    chk1("t5_proto_err_set", proto_err, 1'b1);
    s_axi_arvalid = 1'b1;
    repeat (3) cyc();
    s_axi_arvalid = 1'b0;
    chk1("t5_proto_err_sticky", proto_err, 1'b1);
    chk4("t5_rd_3", rd_outstanding, 4'd3);
    uncore_rstn = 1'b0;
    #1;
    chk1("t5_reset_clears_err", proto_err, 1'b0);
    chk4("t5_reset_clears_rd", rd_outstanding, 4'd0);
    cyc();
    uncore_rstn = 1'b1;
    cyc();

`ifdef AXI_MEM_DRAIN_GATE_STATS_EN
    // Test 6: 3 reads, 2 writes, 7 gated cycles.
    chkw("t6_rst_stats", 128'({stat_rd_bursts, stat_wr_bursts, stat_stall_cyc}), 128'(96'd0));
    s_axi_arvalid = 1'b1;
    repeat (3) cyc();
    s_axi_arvalid = 1'b0;
    s_axi_awvalid = 1'b1;
    repeat (2) cyc();
    s_axi_awvalid = 1'b0;
    quiesce_req = 1'b1;
    cyc();
    s_axi_arvalid = 1'b1;
    repeat (7) cyc();
    s_axi_arvalid = 1'b0;
    chkw("t6_rd_bursts", 128'(stat_rd_bursts), 128'(32'd3));
    chkw("t6_wr_bursts", 128'(stat_wr_bursts), 128'(32'd2));
    chkw("t6_stall_cyc", 128'(stat_stall_cyc), 128'(32'd7));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
